// File: rtl/sa_tile_ctrl.sv
// rtl/sa_tile_ctrl.sv - per-tile sequencer: clear, accumulate, drain, row unload
module sa_tile_ctrl #(
    parameter int ROW_NUM = 16,
    parameter int COL_NUM = 16,
    parameter int K_WIDTH = 12
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic                       cfg_mode,
    input  logic [K_WIDTH-1:0]         cfg_k,
    input  logic                       in_valid,
    output logic                       in_req,
    output logic                       sa_in_zero,
    output logic                       sa_reset,
    output logic                       sa_en,
    output logic                       sa_mode,
    output logic                       sa_ch_out_reset,
    output logic                       sa_ch_out_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(ROW_NUM)-1:0] out_row_idx,
    output logic                       out_last,
    output logic                       busy,
    output logic                       done
);

    localparam int RW = $clog2(ROW_NUM);
    localparam int DW = $clog2(ROW_NUM + COL_NUM);
    localparam logic [RW-1:0] LAST_ROW   = RW'(ROW_NUM - 1);
    localparam logic [DW-1:0] LAST_DRAIN = DW'(ROW_NUM + COL_NUM - 3);
    localparam logic [K_WIDTH-1:0] K_ONE = K_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_COMPUTE,
        S_DRAIN,
        S_OUTPUT,
        S_DONE
    } state_t;

    state_t             state, state_nxt;
    logic [K_WIDTH-1:0] k_q, beat_cnt;
    logic [DW-1:0]      drain_cnt;
    logic [RW-1:0]      row_cnt;
    logic               mode_q, rst_q;
    logic               kill, start_ok, beat, last_beat, drain_end, fire, last_fire;

    assign kill      = abort && (state != S_IDLE);
    assign start_ok  = (state == S_IDLE) && start && !abort && (cfg_k != '0);
    assign beat      = (state == S_COMPUTE) && in_valid;
    assign last_beat = beat && (beat_cnt == k_q - K_ONE);
    assign drain_end = (state == S_DRAIN) && (drain_cnt == LAST_DRAIN);
    assign fire      = (state == S_OUTPUT) && out_ready;
    assign last_fire = fire && (row_cnt == LAST_ROW);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (start_ok) state_nxt = S_CLEAR;
            S_CLEAR:   state_nxt = S_COMPUTE;
            S_COMPUTE: if (last_beat) state_nxt = S_DRAIN;
            S_DRAIN:   if (drain_end) state_nxt = S_OUTPUT;
            S_OUTPUT:  if (last_fire) state_nxt = S_DONE;
            S_DONE:    state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (kill) state_nxt = S_IDLE;

        // abort freezes the array and rewinds its row-unload counter in the same cycle
        in_req          = (state == S_COMPUTE);
        sa_en           = (beat || (state == S_DRAIN)) && !kill;
        sa_in_zero      = (state == S_DRAIN);
        sa_reset        = rst_q || (state == S_CLEAR);
        sa_ch_out_reset = (state == S_CLEAR) || kill;
        sa_ch_out_en    = fire && !kill;
        out_valid       = (state == S_OUTPUT);
        out_row_idx     = row_cnt;
        out_last        = (state == S_OUTPUT) && (row_cnt == LAST_ROW);
        busy            = (state != S_IDLE);
        done            = (state == S_DONE);
        sa_mode         = mode_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_q     <= 1'b1;
            mode_q    <= 1'b0;
            k_q       <= '0;
            beat_cnt  <= '0;
            drain_cnt <= '0;
            row_cnt   <= '0;
        end else begin
            rst_q <= 1'b0;
            if (start_ok) begin
                mode_q <= cfg_mode;
                k_q    <= cfg_k;
            end
            if (kill) begin
                beat_cnt  <= '0;
                drain_cnt <= '0;
                row_cnt   <= '0;
            end else begin
                if (last_beat)             beat_cnt <= '0;
                else if (beat)             beat_cnt <= beat_cnt + K_ONE;
                if (drain_end)             drain_cnt <= '0;
                else if (state == S_DRAIN) drain_cnt <= drain_cnt + DW'(1);
                if (last_fire)             row_cnt <= '0;
                else if (fire)             row_cnt <= row_cnt + RW'(1);
            end
        end
    end

endmodule

// File: tb/tb_sa_tile_ctrl.sv
// tb/tb_sa_tile_ctrl.sv - randomized self-checking bench for sa_tile_ctrl
module tb_sa_tile_ctrl;
    localparam int R = 16, C = 16, KW = 12, D = R + C - 2, MAXC = 400;

    logic clk = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, cfg_mode = 1'b0;
    logic in_valid = 1'b0, out_ready = 1'b0;
    logic [KW-1:0] cfg_k = '0;
    logic in_req, sa_in_zero, sa_reset, sa_en, sa_mode, sa_ch_out_reset, sa_ch_out_en;
    logic out_valid, out_last, busy, done;
    logic [3:0] out_row_idx;

    int checks = 0, passed = 0;
    bit iv[MAXC];
    bit rdy[MAXC];
    logic [14:0] exp_v[MAXC];
    logic [14:0] obs[MAXC];
    int exp_len, exp_done, t_last_beat, t_out;
    bit cur_mode = 1'b0;

    always #5 clk = ~clk;

    sa_tile_ctrl #(.ROW_NUM(R), .COL_NUM(C), .K_WIDTH(KW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_mode(cfg_mode),
        .cfg_k(cfg_k), .in_valid(in_valid), .in_req(in_req), .sa_in_zero(sa_in_zero),
        .sa_reset(sa_reset), .sa_en(sa_en), .sa_mode(sa_mode), .sa_ch_out_reset(sa_ch_out_reset),
        .sa_ch_out_en(sa_ch_out_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_row_idx(out_row_idx), .out_last(out_last), .busy(busy), .done(done)
    );

    // {busy,in_req,sa_en,zero,sa_reset,ch_rst,ch_en,out_valid,out_last,done,mode,idx}
    function automatic logic [14:0] vec(input logic b, ir, en, z, sr, cr, ce, ov, ol, dn, m,
                                        input logic [3:0] idx);
        return {b, ir, en, z, sr, cr, ce, ov, ol, dn, m, idx};
    endfunction

    function automatic logic [14:0] snap();
        return {busy, in_req, sa_en, sa_in_zero, sa_reset, sa_ch_out_reset, sa_ch_out_en,
                out_valid, out_last, done, sa_mode, out_row_idx};
    endfunction

    task automatic fill(input int piv, input int prdy);
        for (int t = 0; t < MAXC; t++) begin
            iv[t]  = (t >= 120) || ($urandom_range(1, 100) <= piv);
            rdy[t] = (t >= 250) || ($urandom_range(1, 100) <= prdy);
        end
    endtask

    // Timeline of one tile, started at cycle 0, derived from beat/fire counting
    task automatic build_expect(input int k, input bit mode);
        int beats = 0, fires = 0, tf = -1;
        t_last_beat = -1;
        for (int t = 2; t < MAXC; t++)
            if (iv[t] && t_last_beat < 0) begin
                beats++;
                if (beats == k) t_last_beat = t;
            end
        t_out = t_last_beat + D + 1;
        for (int t = t_out; t < MAXC; t++)
            if (rdy[t] && tf < 0) begin
                fires++;
                if (fires == R) tf = t;
            end
        exp_done = tf + 1;
        exp_len  = tf + 3;
        fires = 0;
        for (int t = 0; t < exp_len; t++) begin
            if (t == 0)                exp_v[t] = vec(0,0,0,0,0,0,0,0,0,0,cur_mode,0);
            else if (t == 1)           exp_v[t] = vec(1,0,0,0,1,1,0,0,0,0,mode,0);
            else if (t <= t_last_beat) exp_v[t] = vec(1,1,iv[t],0,0,0,0,0,0,0,mode,0);
            else if (t < t_out)        exp_v[t] = vec(1,0,1,1,0,0,0,0,0,0,mode,0);
            else if (t <= tf) begin
                exp_v[t] = vec(1,0,0,0,0,0,rdy[t],1,(fires == R-1),0,mode,4'(fires));
                if (rdy[t]) fires++;
            end
            else if (t == exp_done)    exp_v[t] = vec(1,0,0,0,0,0,0,0,0,1,mode,0);
            else                       exp_v[t] = vec(0,0,0,0,0,0,0,0,0,0,mode,0);
        end
    endtask

    task automatic drive_tile(input int k, input bit mode, input bit noise);
        for (int t = 0; t < exp_len; t++) begin
            if (t == 0) begin
                start = 1'b1; cfg_k = KW'(k); cfg_mode = mode;
            end else begin
                start = (noise && t < exp_len - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
                if (noise) begin
                    cfg_k    = KW'($urandom_range(0, 40));
                    cfg_mode = 1'($urandom_range(0, 1));
                end
            end
            in_valid = iv[t]; out_ready = rdy[t];
            @(negedge clk); obs[t] = snap();
            @(posedge clk); #1;
        end
        start = 1'b0;
        cur_mode = mode;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        checks++;
        if (snap() !== vec(0,0,0,0,1,0,0,0,0,0,0,0))
            $display("FAIL reset_hold got %b want %b", snap(), vec(0,0,0,0,1,0,0,0,0,0,0,0));
        else passed++;
        #1 reset = 1'b1;
        #1 checks++;
        if (sa_reset !== 1'b1) $display("FAIL reset_release_pre_clk sa_reset got %b want 1", sa_reset);
        else passed++;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (snap() !== vec(0,0,0,0,0,0,0,0,0,0,0,0))
            $display("FAIL reset_first_clk got %b want %b", snap(), vec(0,0,0,0,0,0,0,0,0,0,0,0));
        else passed++;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int dcyc = -1, nen = 0;
        for (int t = 0; t < MAXC; t++) begin iv[t] = 1'b1; rdy[t] = 1'b1; end
        build_expect(4, 1'b1);
        drive_tile(4, 1'b1, 1'b0);
        for (int t = 0; t < exp_len; t++) begin
            checks++;
            if (obs[t] !== exp_v[t]) $display("FAIL basic cycle %0d got %b want %b", t, obs[t], exp_v[t]);
            else passed++;
            if (obs[t][5] && dcyc < 0) dcyc = t;
            if (obs[t][8]) nen++;
        end
        checks++;
        if (dcyc !== 52) $display("FAIL basic_done_cycle got %0d want 52", dcyc); else passed++;
        checks++;
        if (nen !== 16) $display("FAIL basic_ch_out_en_count got %0d want 16", nen); else passed++;
    endtask

    task automatic test_toggle();
        int nbeat = 0;
        for (int t = 0; t < MAXC; t++) begin iv[t] = (t < 2) || ((t - 2) % 2 == 0); rdy[t] = 1'b1; end
        build_expect(4, 1'b0);
        drive_tile(4, 1'b0, 1'b1);
        for (int t = 0; t < exp_len; t++) begin
            checks++;
            if (obs[t] !== exp_v[t]) $display("FAIL toggle cycle %0d got %b want %b", t, obs[t], exp_v[t]);
            else passed++;
            if (obs[t][13] && obs[t][12]) nbeat++;
        end
        checks++;
        if (nbeat !== 4) $display("FAIL toggle_beats got %0d want 4", nbeat); else passed++;
    endtask

    task automatic test_stall();
        int k = $urandom_range(1, 20);
        bit m = 1'($urandom_range(0, 1));
        int nfire = 0, ndone = 0;
        fill(70, 100);
        build_expect(k, m);
        for (int t = t_out + 5; t < t_out + 8; t++) rdy[t] = 1'b0;
        build_expect(k, m);
        drive_tile(k, m, 1'b1);
        for (int t = 0; t < exp_len; t++) begin
            checks++;
            if (obs[t] !== exp_v[t]) $display("FAIL stall cycle %0d got %b want %b", t, obs[t], exp_v[t]);
            else passed++;
            if (obs[t][8]) nfire++;
            if (obs[t][5]) ndone++;
        end
        checks++;
        if (obs[t_out + 6][3:0] !== 4'd5) $display("FAIL stall_hold_idx got %0d want 5", obs[t_out + 6][3:0]);
        else passed++;
        checks++;
        if (nfire !== 16 || ndone !== 1)
            $display("FAIL stall_totals got fires=%0d dones=%0d want 16 1", nfire, ndone);
        else passed++;
    endtask

    task automatic test_k0();
        for (int t = 0; t < 6; t++) begin
            start = (t == 0); cfg_k = '0; cfg_mode = ~cur_mode;
            @(negedge clk);
            checks++;
            if ({busy, done, sa_mode} !== {1'b0, 1'b0, cur_mode})
                $display("FAIL k0 cycle %0d got busy=%b done=%b mode=%b want 0 0 %b",
                         t, busy, done, sa_mode, cur_mode);
            else passed++;
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    task automatic test_abort(input bit in_output);
        int k = $urandom_range(1, 8);
        bit m = 1'($urandom_range(0, 1));
        int at;
        for (int t = 0; t < MAXC; t++) begin iv[t] = 1'b1; rdy[t] = 1'b1; end
        build_expect(k, m);
        at = in_output ? t_out + $urandom_range(0, R - 1) : t_last_beat + 1 + $urandom_range(0, D - 1);
        for (int t = 0; t < at + 6; t++) begin
            start = (t == 0); cfg_k = KW'(k); cfg_mode = m;
            abort = (t == at); in_valid = 1'b1; out_ready = 1'b1;
            @(negedge clk);
            checks++;
            if (t < at) begin
                if (snap() !== exp_v[t]) $display("FAIL abort_pre cycle %0d got %b want %b", t, snap(), exp_v[t]);
                else passed++;
            end else if (t == at) begin
                if ({busy, sa_ch_out_reset, sa_en} !== 3'b110)
                    $display("FAIL abort_cycle got busy/ch_rst/en=%b want 110", {busy, sa_ch_out_reset, sa_en});
                else passed++;
            end else begin
                if ({busy, done} !== 2'b00) $display("FAIL abort_after cycle %0d got busy/done=%b want 00", t, {busy, done});
                else passed++;
            end
            @(posedge clk); #1;
        end
        abort = 1'b0; start = 1'b0; cur_mode = m;
        start = 1'b1; abort = 1'b1; cfg_k = KW'(5); cfg_mode = ~m;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, sa_mode} !== {1'b0, m}) $display("FAIL start_with_abort got busy/mode=%b want 0%b", {busy, sa_mode}, m);
        else passed++;
        @(posedge clk); #1;
        build_expect(1, ~m);
        drive_tile(1, ~m, 1'b0);
        for (int t = 0; t < exp_len; t++) begin
            checks++;
            if (obs[t] !== exp_v[t]) $display("FAIL post_abort cycle %0d got %b want %b", t, obs[t], exp_v[t]);
            else passed++;
        end
    endtask

    task automatic test_reset_mid();
        for (int t = 0; t < 5; t++) begin
            start = (t == 0); cfg_k = KW'(10); cfg_mode = 1'b1; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        start = 1'b0;
        reset = 1'b0;
        #1 checks++;
        if (snap() !== vec(0,0,0,0,1,0,0,0,0,0,0,0))
            $display("FAIL reset_mid_async got %b want %b", snap(), vec(0,0,0,0,1,0,0,0,0,0,0,0));
        else passed++;
        @(negedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (snap() !== vec(0,0,0,0,0,0,0,0,0,0,0,0))
            $display("FAIL reset_mid_idle got %b want %b", snap(), vec(0,0,0,0,0,0,0,0,0,0,0,0));
        else passed++;
        cur_mode = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            int k = $urandom_range(1, 20);
            bit m = 1'($urandom_range(0, 1));
            fill(70, 70);
            build_expect(k, m);
            drive_tile(k, m, 1'b1);
            for (int t = 0; t < exp_len; t++) begin
                checks++;
                if (obs[t] !== exp_v[t]) $display("FAIL random%0d cycle %0d got %b want %b", n, t, obs[t], exp_v[t]);
                else passed++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_toggle();
        test_stall();
        test_k0();
        test_abort(1'b0);
        test_abort(1'b1);
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule

// File: doc/sa_tile_ctrl.md
Name: sa_tile_ctrl

Overview:
- Per-tile sequencer for the 16x16 weight-stationary-free systolic array.
- Clears the PE accumulators, streams cfg_k operand beats with stall support, drains the array skew, then unloads the ROW_NUM result rows through a valid/ready handshake by pulsing the array's channel_out_en.
- Sits between the tile scheduler (start/done) and the array plus its operand feeders and output writer.

Parameters:
ROW_NUM, 16, array rows; number of result rows unloaded per tile
COL_NUM, 16, array columns; used for the drain length only
K_WIDTH, 12, width of the accumulation-beat count

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-low reset
start  in  1  tile start request; sampled only in IDLE
abort  in  1  synchronous abort; returns to IDLE from any state
cfg_mode  in  1  0 = 8x8 mode, 1 = 1x8 mode; latched on accepted start
cfg_k  in  K_WIDTH  operand beats to accumulate; latched on accepted start
in_valid  in  1  feeders have the current operand beat on row_in/column_in
in_req  out  1  controller consumes a beat this cycle if in_valid
sa_in_zero  out  1  feeders must drive zero operands (drain phase)
sa_reset  out  1  array synchronous clear, active-high
sa_en  out  1  array advance enable
sa_mode  out  1  array mode, held constant for the whole tile
sa_ch_out_reset  out  1  array row-unload counter clear
sa_ch_out_en  out  1  array row-unload strobe; the array output is valid in the same cycle
out_valid  out  1  result row available
out_ready  in  1  writer accepts a row
out_row_idx  out  log2(ROW_NUM)  index of the row offered
out_last  out  1  offered row is ROW_NUM-1
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at tile completion

Behaviour:
- While reset is low: state = IDLE, all counters 0, sa_mode = 0, sa_reset = 1, and every other output 0.
  - The first clock after reset deasserts drops sa_reset to 0.
- All outputs are decoded from registered state and counters; there is no combinational path from start to any output.
- States and transitions:
  - IDLE:
    - start=1 with cfg_k!=0 latches cfg_mode and cfg_k, then goes to CLEAR.
    - start with cfg_k==0 is ignored: no done, no state change.
  - CLEAR (1 cycle):
    - sa_reset=1 and sa_ch_out_reset=1; sa_mode already shows the latched mode.
    - Goes to COMPUTE.
  - COMPUTE:
    - in_req=1 and sa_en=in_valid.
    - beat_cnt increments on in_valid.
    - On the cycle beat_cnt==k-1 with in_valid=1, goes to DRAIN.
    - With in_valid=0 the array is frozen (sa_en=0) and no beat is counted.
  - DRAIN:
    - sa_en=1, sa_in_zero=1, in_req=0.
    - Lasts ROW_NUM+COL_NUM-2 cycles (30 at defaults), counted by drain_cnt, then goes to OUTPUT.
  - OUTPUT:
    - out_valid=1 and sa_ch_out_en=out_ready.
    - out_row_idx=row_cnt and out_last=(row_cnt==ROW_NUM-1).
    - row_cnt increments on each fire (valid & ready); the fire with out_last=1 goes to DONE.
    - out_ready=0 holds the row; the array row counter does not move because sa_ch_out_en=0.
  - DONE (1 cycle): done=1, then goes to IDLE. A start in DONE is ignored.
- abort=1 in any non-IDLE state:
  - The next state is IDLE.
  - In the abort cycle sa_ch_out_reset=1 and sa_en=0.
  - No done pulse; counters are cleared.
  - abort has priority over every other transition.
  - abort in IDLE has no effect; start is not accepted in the same cycle as abort.
- sa_mode changes only on an accepted start; cfg_* changes mid-tile are ignored.
- Counter widths:
  - beat_cnt is K_WIDTH bits.
  - drain_cnt is clog2(ROW_NUM+COL_NUM) bits.
  - row_cnt is clog2(ROW_NUM) bits and never wraps within a tile.
- Minimum tile latency (in_valid and out_ready held high): start accepted at cycle 0, then CLEAR 1 cycle, COMPUTE k cycles, DRAIN ROW_NUM+COL_NUM-2 cycles, OUTPUT ROW_NUM cycles, and done in the next cycle.

Test Plan:
- Reset release, then start with k=4, mode=1, in_valid=1, out_ready=1:
  - CLEAR at cycle 1, sa_en high cycles 2-5, sa_in_zero cycles 6-35.
  - sa_ch_out_en cycles 36-51 with out_row_idx 0..15 and out_last at 51.
  - done at 52; sa_mode=1 throughout.
- Same tile with in_valid toggling 1,0,1,0,...: sa_en follows in_valid; exactly 4 counted beats; DRAIN starts after the 4th valid beat.
- OUTPUT with out_ready low for 3 cycles on row 5: out_row_idx holds 5, sa_ch_out_en=0 for those cycles, 16 total fires, single done.
- Start with cfg_k=0: busy stays 0, no done.
- Start in DONE or during COMPUTE: ignored; only one tile runs.
- Abort in DRAIN and in OUTPUT: IDLE next cycle, sa_ch_out_reset pulses, no done; a following start with k=1 completes normally.
- Reset asserted mid-COMPUTE: outputs go immediately to reset values with sa_reset=1; after release the block is in IDLE.
